// File: rtl/fact_pkg.sv
// Shared definitions for the factorial sequencer: state encoding and opdone status codes.
package fact_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_MUL     = 3'd2;
  localparam state_t ST_WAIT    = 3'd3;
  localparam state_t ST_UPDATE  = 3'd4;
  localparam state_t ST_M_CLEAR = 3'd5;
  localparam state_t ST_DONE    = 3'd6;

  localparam logic [1:0] OPDONE_IDLE = 2'b00;
  localparam logic [1:0] OPDONE_BUSY = 2'b10;
  localparam logic [1:0] OPDONE_DONE = 2'b11;

endpackage

// File: rtl/fact_ctrl_param_if.sv
// Start/done handshake between the factorial sequencer (master) and the multiplier core (slave).
interface fact_ctrl_param_if #(
  parameter int RWIDTH = 64
);

  logic                  m_opstart;
  logic                  m_opclear;
  logic [RWIDTH-1:0]     m_multiplicand;
  logic [RWIDTH-1:0]     m_multiplier;
  logic                  m_opdone;
  logic [2*RWIDTH-1:0]   m_result;

  modport master (
    output m_opstart, m_opclear, m_multiplicand, m_multiplier,
    input  m_opdone, m_result
  );

  modport slave (
    input  m_opstart, m_opclear, m_multiplicand, m_multiplier,
    output m_opdone, m_result
  );

endinterface

// File: rtl/fact_ctrl_ns.sv
// Next-state function of the factorial sequencer; opclear overrides every transition.
module fact_ctrl_ns
  import fact_pkg::*;
(
  input  state_t state,
  input  logic   opstart,
  input  logic   opclear,
  input  logic   cnt_le1,
  input  logic   cnt_le2,
  input  logic   m_opdone,
  output state_t n_state
);

  always_comb begin
    // NOTE: default first so every path assigns n_state and no latch is inferred.
    n_state = state;
    case (state)
      ST_IDLE:    if (opstart)  n_state = ST_LOAD;
      ST_LOAD:    n_state = cnt_le1 ? ST_DONE : ST_MUL;
      ST_MUL:     n_state = ST_WAIT;
      ST_WAIT:    if (m_opdone) n_state = ST_UPDATE;
      ST_UPDATE:  n_state = cnt_le2 ? ST_DONE : ST_M_CLEAR;
      ST_M_CLEAR: n_state = ST_MUL;
      ST_DONE:    n_state = ST_DONE;
      default:    n_state = ST_IDLE;
    endcase
    if (opclear) n_state = ST_IDLE;
  end

endmodule

// File: rtl/fact_ctrl_param.sv
// Factorial sequencer: computes operand! by iterating an external multiplier over a start/done handshake.
module fact_ctrl_param
  import fact_pkg::*;
#(
  parameter int OWIDTH = 8,
  parameter int RWIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              opstart,
  input  logic              opclear,
  input  logic [OWIDTH-1:0] operand,
  output logic [1:0]        opdone,
  output logic [RWIDTH-1:0] result,
  output logic              overflow,
  fact_ctrl_param_if.master mif
);

  state_t            state;
  state_t            n_state;
  logic [RWIDTH-1:0] acc;
  logic [OWIDTH-1:0] cnt;
  logic              cnt_le1;
  logic              cnt_le2;

  assign cnt_le1 = (cnt <= OWIDTH'(1));
  // Finishing on cnt<=2 also lets n=2 stop after its single 2*1 multiply.
  assign cnt_le2 = (cnt <= OWIDTH'(2));

  fact_ctrl_ns u_ns (
    .state    (state),
    .opstart  (opstart),
    .opclear  (opclear),
    .cnt_le1  (cnt_le1),
    .cnt_le2  (cnt_le2),
    .m_opdone (mif.m_opdone),
    .n_state  (n_state)
  );

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state <= ST_IDLE;
    else       state <= n_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (opclear) begin
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (opstart) begin
            cnt      <= operand;
            overflow <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (cnt_le1) begin
            acc <= RWIDTH'(1);
          end else begin
            acc <= RWIDTH'(cnt);
            cnt <= cnt - OWIDTH'(1);
          end
        end
        ST_UPDATE: begin
          acc      <= mif.m_result[RWIDTH-1:0];
          overflow <= overflow | (|mif.m_result[2*RWIDTH-1:RWIDTH]);
          if (!cnt_le2) cnt <= cnt - OWIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // acc and cnt only move in LOAD/UPDATE, so the operands stay stable through MUL and WAIT.
  always_comb begin
    opdone             = OPDONE_BUSY;
    result             = '0;
    mif.m_opstart      = 1'b0;
    mif.m_opclear      = opclear && (state != ST_IDLE);
    mif.m_multiplicand = acc;
    mif.m_multiplier   = RWIDTH'(cnt);
    case (state)
      ST_IDLE:    opdone = OPDONE_IDLE;
      ST_MUL:     mif.m_opstart = 1'b1;
      ST_M_CLEAR: mif.m_opclear = 1'b1;
      ST_DONE: begin
        opdone = OPDONE_DONE;
        result = acc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fact_ctrl_param.sv
// Bench for fact_ctrl_param: 3-cycle behavioural multiplier, scoreboard of expected factorials.
module tb_fact_ctrl_param;
  import fact_pkg::*;

  localparam int OWIDTH = 8;
  localparam int RWIDTH = 64;

  typedef struct {
    logic [RWIDTH-1:0] res;
    logic              ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              opstart;
  logic              opclear;
  logic [OWIDTH-1:0] operand;
  logic [1:0]        opdone;
  logic [RWIDTH-1:0] result;
  logic              overflow;

  fact_ctrl_param_if #(.RWIDTH(RWIDTH)) mif ();

  fact_ctrl_param #(.OWIDTH(OWIDTH), .RWIDTH(RWIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .opstart  (opstart),
    .opclear  (opclear),
    .operand  (operand),
    .opdone   (opdone),
    .result   (result),
    .overflow (overflow),
    .mif      (mif.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  int mul_cnt;
  logic [RWIDTH-1:0] mults[$];
  logic [RWIDTH-1:0] mcands[$];
  int last_edges;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Multiplier model: product appears 3 edges after m_opstart, held until m_opclear.
  logic [1:0]   lat;
  logic         mbusy;
  logic [127:0] prod;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mif.m_opdone <= 1'b0;
      mif.m_result <= '0;
      mbusy        <= 1'b0;
      lat          <= '0;
      prod         <= '0;
    end else if (mif.m_opclear) begin
      mif.m_opdone <= 1'b0;
      mif.m_result <= '0;
      mbusy        <= 1'b0;
    end else if (mif.m_opstart) begin
      mbusy <= 1'b1;
      lat   <= 2'd3;
      prod  <= 128'(mif.m_multiplicand) * 128'(mif.m_multiplier);
    end else if (mbusy) begin
      lat <= lat - 2'd1;
      if (lat == 2'd1) begin
        mif.m_opdone <= 1'b1;
        mif.m_result <= prod;
        mbusy        <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mif.m_opstart) begin
      mul_cnt++;
      mults.push_back(mif.m_multiplier);
      mcands.push_back(mif.m_multiplicand);
    end
  end

  function automatic void model(input int n, output logic [RWIDTH-1:0] r, output logic o);
    logic [127:0] p;
    r = 1;
    o = 1'b0;
    for (int i = 2; i <= n; i++) begin
      p = {64'd0, r} * 128'(unsigned'(i));
      if (p[127:64] != 0) o = 1'b1;
      r = p[63:0];
    end
  endfunction

  task automatic run(input int n, input bit poke);
    exp_t e;
    exp_t got;
    int   edges;
    model(n, e.res, e.ovf);
    sb.push_back(e);
    mul_cnt = 0;
    mults.delete();
    mcands.delete();
    @(negedge clk);
    operand = OWIDTH'(n);
    opstart = 1'b1;
    @(negedge clk);
    opstart = 1'b0;
    edges   = 1;
    while (opdone !== OPDONE_DONE && edges < 4000) begin
      if (poke) begin
        opstart = edges[0];
        operand = 8'd2;
      end
      @(negedge clk);
      edges++;
    end
    last_edges = edges;
    check($sformatf("done_%0d", n), opdone, OPDONE_DONE);
    got = sb.pop_front();
    check($sformatf("result_%0d", n), result, got.res);
    check($sformatf("ovf_%0d", n), overflow, got.ovf);
    if (poke) begin
      opstart = 1'b1;
      repeat (3) @(negedge clk);
      check("done_hold_opstart", opdone, OPDONE_DONE);
      check("result_hold_opstart", result, got.res);
    end
    opclear = 1'b1;
    opstart = 1'b0;
    @(negedge clk);
    opclear = 1'b0;
    check($sformatf("clr_opdone_%0d", n), opdone, OPDONE_IDLE);
    check($sformatf("clr_result_%0d", n), result, 0);
    check($sformatf("clr_ovf_%0d", n), overflow, 0);
  endtask

  task automatic wait_mul(input string tag);
    int k = 0;
    while (mif.m_opstart !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(tag, mif.m_opstart, 1);
  endtask

  initial begin
    reset   = 1'b1;
    opstart = 1'b0;
    opclear = 1'b0;
    operand = '0;
    repeat (2) @(negedge clk);
    check("rst_opdone", opdone, OPDONE_IDLE);
    check("rst_result", result, 0);
    check("rst_ovf", overflow, 0);
    check("rst_mstart", mif.m_opstart, 0);
    check("rst_mclear", mif.m_opclear, 0);
    check("rst_mcand", mif.m_multiplicand, 0);
    check("rst_mplier", mif.m_multiplier, 0);
    reset = 1'b0;
    @(negedge clk);

    run(5, 1'b0);
    check("mul_cnt_5", mul_cnt, 3);
    if (mults.size() == 3 && mcands.size() == 3) begin
      check("mplier_5_0", mults[0], 4);
      check("mplier_5_1", mults[1], 3);
      check("mplier_5_2", mults[2], 2);
      check("mcand_5_0", mcands[0], 5);
      check("mcand_5_1", mcands[1], 20);
      check("mcand_5_2", mcands[2], 60);
    end else begin
      check("mul_q_size_5", mults.size(), 3);
    end

    for (int n = 0; n <= 1; n++) begin
      run(n, 1'b0);
      check($sformatf("mul_cnt_%0d", n), mul_cnt, 0);
      check($sformatf("latency_%0d", n), last_edges, 2);
      check($sformatf("res_const_%0d", n), 64'd1, 64'd1 & {64{1'b1}});
    end

    run(2, 1'b0);
    check("mul_cnt_2", mul_cnt, 1);
    run(3, 1'b0);
    run(20, 1'b0);
    run(21, 1'b0);

    // 20! against the literal value, independent of the model
    @(negedge clk);
    operand = 8'd20;
    opstart = 1'b1;
    @(negedge clk);
    opstart = 1'b0;
    for (int k = 0; k < 500 && opdone !== OPDONE_DONE; k++) @(negedge clk);
    check("result_20_lit", result, 64'h21C3677C82B40000);
    check("ovf_20_lit", overflow, 0);
    opclear = 1'b1;
    @(negedge clk);
    opclear = 1'b0;

    // abort in WAIT during 10!
    operand = 8'd10;
    opstart = 1'b1;
    @(negedge clk);
    opstart = 1'b0;
    wait_mul("abort_reach_mul");
    @(negedge clk);
    check("abort_busy", opdone, OPDONE_BUSY);
    opclear = 1'b1;
    #1;
    check("abort_mclear_on", mif.m_opclear, 1);
    @(negedge clk);
    opclear = 1'b0;
    #1;
    check("abort_mclear_off", mif.m_opclear, 0);
    check("abort_opdone", opdone, OPDONE_IDLE);
    check("abort_result", result, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("abort_idle_mclear", mif.m_opclear, 0);
      check("abort_idle_mstart", mif.m_opstart, 0);
    end
    run(3, 1'b0);

    // opstart pulsed while busy and held in DONE
    run(6, 1'b1);

    // asynchronous reset while in MUL
    @(negedge clk);
    operand = 8'd7;
    opstart = 1'b1;
    @(negedge clk);
    opstart = 1'b0;
    wait_mul("arst_reach_mul");
    #2;
    reset = 1'b1;
    #1;
    check("arst_opdone", opdone, OPDONE_IDLE);
    check("arst_mstart", mif.m_opstart, 0);
    check("arst_mcand", mif.m_multiplicand, 0);
    check("arst_mplier", mif.m_multiplier, 0);
    check("arst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("arst_idle", opdone, OPDONE_IDLE);
    run(4, 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule
